// File: rtl/inst_issue_queue_if.sv
// Handshake and data bundle between the fetch/decode side and the issue queue.
// The queue itself connects through the slave modport.
interface inst_issue_queue_if #(
    parameter int DEPTH  = 32,
    parameter int INST_W = 32,
    parameter int PC_W   = 32,
    parameter int EXP_W  = 14
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic              flush;
    logic [1:0]        wr_en;
    logic [INST_W-1:0] wr_inst0, wr_inst1;
    logic [PC_W-1:0]   wr_pc0, wr_pc1;
    logic [EXP_W-1:0]  wr_exp0, wr_exp1;
    logic              wr_ready;
    logic [1:0]        rd_en;
    logic [1:0]        rd_branch;
    logic [1:0]        rd_valid;
    logic [INST_W-1:0] rd_inst0, rd_inst1;
    logic [PC_W-1:0]   rd_pc0, rd_pc1;
    logic [EXP_W-1:0]  rd_exp0, rd_exp1;
    logic              rd_ds0;
    logic [CW-1:0]     count;
    logic              empty, almost_full, full;

    modport master (
        output flush, wr_en, wr_inst0, wr_inst1, wr_pc0, wr_pc1, wr_exp0, wr_exp1,
        output rd_en, rd_branch,
        input  wr_ready, rd_valid, rd_inst0, rd_inst1, rd_pc0, rd_pc1, rd_exp0, rd_exp1,
        input  rd_ds0, count, empty, almost_full, full
    );

    modport slave (
        input  flush, wr_en, wr_inst0, wr_inst1, wr_pc0, wr_pc1, wr_exp0, wr_exp1,
        input  rd_en, rd_branch,
        output wr_ready, rd_valid, rd_inst0, rd_inst1, rd_pc0, rd_pc1, rd_exp0, rd_exp1,
        output rd_ds0, count, empty, almost_full, full
    );
endinterface

// File: rtl/inst_issue_queue.sv
// Dual-push / dual-pop circular instruction issue queue with branch delay-slot
// tracking; head and head+1 are presented combinationally.
module inst_issue_queue #(
    parameter int DEPTH    = 32,
    parameter int INST_W   = 32,
    parameter int PC_W     = 32,
    parameter int EXP_W    = 14,
    parameter int AFULL_TH = 4
) (
    input logic                clk,
    input logic                rst,
    inst_issue_queue_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C = CW'(AFULL_TH);

    logic [INST_W-1:0] r_inst [DEPTH];
    logic [PC_W-1:0]   r_pc   [DEPTH];
    logic [EXP_W-1:0]  r_exp  [DEPTH];

    logic [AW-1:0] r_rd_ptr, r_wr_ptr;
    logic [CW-1:0] r_count;
    logic          r_ds;

    logic [CW-1:0] w_free;
    logic          w_wr_ready;
    logic [1:0]    w_rd_valid;
    logic          w_push;
    logic [1:0]    w_pushes;
    logic [1:0]    w_pops;
    logic [AW-1:0] w_wr_ptr1, w_rd_ptr1;

    assign w_free     = DEPTH_C - r_count;
    assign w_wr_ready = (w_free >= CW'(2));
    assign w_rd_valid = {r_count >= CW'(2), r_count != '0};

    // Slot1 is only meaningful together with slot0; pushes are all-or-nothing.
    assign w_push   = w_wr_ready & bus.wr_en[0] & ~bus.flush;
    assign w_pushes = w_push ? (bus.wr_en[1] ? 2'd2 : 2'd1) : 2'd0;
    assign w_pops   = {1'b0, bus.rd_en[0] & w_rd_valid[0]}
                    + {1'b0, bus.rd_en[1] & bus.rd_en[0] & w_rd_valid[1]};

    assign w_wr_ptr1 = r_wr_ptr + AW'(1);
    assign w_rd_ptr1 = r_rd_ptr + AW'(1);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_inst[r_wr_ptr] <= bus.wr_inst0;
            r_pc[r_wr_ptr]   <= bus.wr_pc0;
            r_exp[r_wr_ptr]  <= bus.wr_exp0;
            if (bus.wr_en[1]) begin
                r_inst[w_wr_ptr1] <= bus.wr_inst1;
                r_pc[w_wr_ptr1]   <= bus.wr_pc1;
                r_exp[w_wr_ptr1]  <= bus.wr_exp1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_ds     <= 1'b0;
        end else if (bus.flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_ds     <= 1'b0;
        end else begin
            r_wr_ptr <= r_wr_ptr + AW'(w_pushes);
            r_rd_ptr <= r_rd_ptr + AW'(w_pops);
            r_count  <= r_count + CW'(w_pushes) - CW'(w_pops);
            // The instruction after the last popped branch becomes the new head.
            if (w_pops == 2'd1)
                r_ds <= bus.rd_branch[0];
            else if (w_pops == 2'd2)
                r_ds <= bus.rd_branch[1];
        end
    end

    assign bus.rd_valid = w_rd_valid;
    assign bus.rd_inst0 = w_rd_valid[0] ? r_inst[r_rd_ptr]  : '0;
    assign bus.rd_pc0   = w_rd_valid[0] ? r_pc[r_rd_ptr]    : '0;
    assign bus.rd_exp0  = w_rd_valid[0] ? r_exp[r_rd_ptr]   : '0;
    assign bus.rd_inst1 = w_rd_valid[1] ? r_inst[w_rd_ptr1] : '0;
    assign bus.rd_pc1   = w_rd_valid[1] ? r_pc[w_rd_ptr1]   : '0;
    assign bus.rd_exp1  = w_rd_valid[1] ? r_exp[w_rd_ptr1]  : '0;
    assign bus.rd_ds0   = r_ds & w_rd_valid[0];

    assign bus.count       = r_count;
    assign bus.empty       = (r_count == '0);
    assign bus.full        = (r_count == DEPTH_C);
    assign bus.almost_full = (w_free <= AFULL_C);
    assign bus.wr_ready    = w_wr_ready;
endmodule

// File: tb/tb_inst_issue_queue.sv
// Bench for inst_issue_queue: vector table, directed corner sequences and
// random traffic, all compared against a queue-based reference model.
module tb_inst_issue_queue;
    localparam int DEPTH    = 32;
    localparam int INST_W   = 32;
    localparam int PC_W     = 32;
    localparam int EXP_W    = 14;
    localparam int AFULL_TH = 4;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [PC_W-1:0]   pc;
        logic [EXP_W-1:0]  exp;
    } ent_t;

    typedef struct {
        logic       fl;
        logic [1:0] we;
        logic [1:0] re;
        logic [1:0] rb;
        int         exp_cnt;
        logic       exp_ds;
    } vec_t;

    logic clk = 1'b0;
    logic rst;

    inst_issue_queue_if #(.DEPTH(DEPTH), .INST_W(INST_W), .PC_W(PC_W), .EXP_W(EXP_W)) bus ();

    inst_issue_queue #(
        .DEPTH(DEPTH), .INST_W(INST_W), .PC_W(PC_W), .EXP_W(EXP_W), .AFULL_TH(AFULL_TH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_err    = 0;
    ent_t mq[$];
    bit   mds;
    int unsigned pc_seq = 32'h100;
    ent_t z = '0;
    vec_t tbl[15];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    function automatic ent_t mk();
        ent_t e;
        e.inst = $urandom;
        e.pc   = pc_seq;
        e.exp  = EXP_W'($urandom);
        pc_seq = pc_seq + 4;
        return e;
    endfunction

    task automatic model_step(input logic fl, input logic [1:0] we, re, rb, input ent_t d0, d1);
        int cnt = mq.size();
        int pops = 0;
        bit wrdy = ((DEPTH - cnt) >= 2);
        if (re[0] && cnt >= 1) pops++;
        if (re[1] && re[0] && cnt >= 2) pops++;
        if (fl) begin
            mq.delete();
            mds = 1'b0;
        end else begin
            if (pops == 1) mds = rb[0];
            else if (pops == 2) mds = rb[1];
            repeat (pops) void'(mq.pop_front());
            if (wrdy && we[0]) begin
                mq.push_back(d0);
                if (we[1]) mq.push_back(d1);
            end
        end
    endtask

    task automatic compare_all(input string tag);
        int   cnt = mq.size();
        ent_t h0 = '0;
        ent_t h1 = '0;
        if (cnt >= 1) h0 = mq[0];
        if (cnt >= 2) h1 = mq[1];
        chk({tag, ".count"},    64'(bus.count),       64'(cnt));
        chk({tag, ".empty"},    64'(bus.empty),       64'(cnt == 0));
        chk({tag, ".full"},     64'(bus.full),        64'(cnt == DEPTH));
        chk({tag, ".afull"},    64'(bus.almost_full), 64'((DEPTH - cnt) <= AFULL_TH));
        chk({tag, ".wr_ready"}, 64'(bus.wr_ready),    64'((DEPTH - cnt) >= 2));
        chk({tag, ".rd_valid"}, 64'(bus.rd_valid),    64'({cnt >= 2, cnt >= 1}));
        chk({tag, ".rd_inst0"}, 64'(bus.rd_inst0),    64'(h0.inst));
        chk({tag, ".rd_pc0"},   64'(bus.rd_pc0),      64'(h0.pc));
        chk({tag, ".rd_exp0"},  64'(bus.rd_exp0),     64'(h0.exp));
        chk({tag, ".rd_inst1"}, 64'(bus.rd_inst1),    64'(h1.inst));
        chk({tag, ".rd_pc1"},   64'(bus.rd_pc1),      64'(h1.pc));
        chk({tag, ".rd_exp1"},  64'(bus.rd_exp1),     64'(h1.exp));
        chk({tag, ".rd_ds0"},   64'(bus.rd_ds0),      64'(mds && cnt >= 1));
    endtask

    task automatic cycle(input logic fl, input logic [1:0] we, re, rb,
                         input ent_t d0, d1, input string tag);
        bus.flush     = fl;
        bus.wr_en     = we;
        bus.rd_en     = re;
        bus.rd_branch = rb;
        bus.wr_inst0  = d0.inst;
        bus.wr_pc0    = d0.pc;
        bus.wr_exp0   = d0.exp;
        bus.wr_inst1  = d1.inst;
        bus.wr_pc1    = d1.pc;
        bus.wr_exp1   = d1.exp;
        model_step(fl, we, re, rb, d0, d1);
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    task automatic idle_inputs();
        bus.flush = 0; bus.wr_en = 0; bus.rd_en = 0; bus.rd_branch = 0;
        bus.wr_inst0 = 0; bus.wr_pc0 = 0; bus.wr_exp0 = 0;
        bus.wr_inst1 = 0; bus.wr_pc1 = 0; bus.wr_exp1 = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{1'b0, 2'b11, 2'b00, 2'b00, 2, 1'b0};
        tbl[1]  = '{1'b0, 2'b10, 2'b00, 2'b00, 2, 1'b0};
        tbl[2]  = '{1'b0, 2'b01, 2'b00, 2'b00, 3, 1'b0};
        tbl[3]  = '{1'b0, 2'b00, 2'b01, 2'b01, 2, 1'b1};
        tbl[4]  = '{1'b0, 2'b01, 2'b00, 2'b00, 3, 1'b1};
        tbl[5]  = '{1'b0, 2'b00, 2'b11, 2'b01, 1, 1'b0};
        tbl[6]  = '{1'b0, 2'b11, 2'b00, 2'b00, 3, 1'b0};
        tbl[7]  = '{1'b0, 2'b00, 2'b10, 2'b11, 3, 1'b0};
        tbl[8]  = '{1'b0, 2'b11, 2'b11, 2'b10, 3, 1'b1};
        tbl[9]  = '{1'b1, 2'b11, 2'b11, 2'b11, 0, 1'b0};
        tbl[10] = '{1'b0, 2'b00, 2'b11, 2'b00, 0, 1'b0};
        tbl[11] = '{1'b0, 2'b01, 2'b00, 2'b00, 1, 1'b0};
        tbl[12] = '{1'b0, 2'b11, 2'b11, 2'b00, 2, 1'b0};
        tbl[13] = '{1'b0, 2'b00, 2'b01, 2'b01, 1, 1'b1};
        tbl[14] = '{1'b0, 2'b00, 2'b01, 2'b00, 0, 1'b0};

        rst = 1'b1;
        mds = 1'b0;
        idle_inputs();
        #12;
        compare_all("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;
        compare_all("post_reset");

        for (int i = 0; i < 15; i++) begin
            ent_t d0, d1;
            d0 = mk();
            d1 = mk();
            cycle(tbl[i].fl, tbl[i].we, tbl[i].re, tbl[i].rb, d0, d1, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d.tbl_count", i), 64'(bus.count), 64'(tbl[i].exp_cnt));
            chk($sformatf("vec%0d.tbl_ds0", i), 64'(bus.rd_ds0), 64'(tbl[i].exp_ds));
        end

        begin : mixed
            ent_t d0, d1;
            cycle(1'b1, 2'b00, 2'b00, 2'b00, z, z, "mix_flush");
            cycle(1'b0, 2'b01, 2'b00, 2'b00, mk(), z, "mix_one");
            d0 = mk();
            d1 = mk();
            d1.exp = ~d0.exp;
            cycle(1'b0, 2'b11, 2'b11, 2'b00, d0, d1, "mix");
            chk("mix.count", 64'(bus.count), 64'd2);
            chk("mix.rd_exp0", 64'(bus.rd_exp0), 64'(d0.exp));
            chk("mix.rd_exp1", 64'(bus.rd_exp1), 64'(d1.exp));
        end

        cycle(1'b1, 2'b00, 2'b00, 2'b00, z, z, "fill_flush");
        for (int i = 0; i < 16; i++) cycle(1'b0, 2'b11, 2'b00, 2'b00, mk(), mk(), "fill");
        chk("fill.count", 64'(bus.count), 64'd32);
        chk("fill.full", 64'(bus.full), 64'd1);
        chk("fill.wr_ready", 64'(bus.wr_ready), 64'd0);
        cycle(1'b0, 2'b11, 2'b00, 2'b00, mk(), mk(), "fill_reject");
        chk("fill_reject.count", 64'(bus.count), 64'd32);
        for (int i = 0; i < 16; i++) cycle(1'b0, 2'b00, 2'b11, 2'b00, z, z, "drain");

        begin : wrap
            logic [PC_W-1:0] prev;
            cycle(1'b1, 2'b00, 2'b00, 2'b00, z, z, "wrap_flush");
            for (int i = 0; i < 15; i++) cycle(1'b0, 2'b11, 2'b00, 2'b00, mk(), mk(), "wrap_push");
            for (int i = 0; i < 14; i++) cycle(1'b0, 2'b00, 2'b11, 2'b00, z, z, "wrap_pop");
            cycle(1'b0, 2'b00, 2'b01, 2'b00, z, z, "wrap_pop1");
            for (int i = 0; i < 2; i++) cycle(1'b0, 2'b11, 2'b00, 2'b00, mk(), mk(), "wrap_push2");
            chk("wrap.count", 64'(bus.count), 64'd5);
            prev = bus.rd_pc0;
            for (int i = 0; i < 4; i++) begin
                cycle(1'b0, 2'b00, 2'b01, 2'b00, z, z, "wrap_order");
                chk($sformatf("wrap.pc_order%0d", i), 64'(bus.rd_pc0), 64'(prev + 4));
                prev = bus.rd_pc0;
            end
        end

        cycle(1'b1, 2'b00, 2'b00, 2'b00, z, z, "dsf_flush");
        for (int i = 0; i < 4; i++) cycle(1'b0, 2'b11, 2'b00, 2'b00, mk(), mk(), "dsf_push");
        cycle(1'b0, 2'b00, 2'b01, 2'b01, z, z, "dsf_pop");
        chk("dsf.count7", 64'(bus.count), 64'd7);
        chk("dsf.ds_set", 64'(bus.rd_ds0), 64'd1);
        cycle(1'b1, 2'b11, 2'b11, 2'b11, mk(), mk(), "dsf_flush7");
        chk("dsf.count0", 64'(bus.count), 64'd0);
        chk("dsf.empty", 64'(bus.empty), 64'd1);
        chk("dsf.ds_clr", 64'(bus.rd_ds0), 64'd0);

        for (int i = 0; i < 3; i++) cycle(1'b0, 2'b11, 2'b00, 2'b00, mk(), mk(), "ar_push");
        cycle(1'b0, 2'b00, 2'b01, 2'b01, z, z, "ar_pop");
        idle_inputs();
        #3;
        rst = 1'b1;
        #1;
        mq.delete();
        mds = 1'b0;
        compare_all("async_rst");
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        compare_all("after_async_rst");

        for (int i = 0; i < 1500; i++) begin
            logic       fl;
            logic [1:0] we, re, rb;
            bit         fill_phase = ((i / 200) % 2) == 0;
            fl = ($urandom_range(0, 99) == 0);
            we = 2'($urandom);
            re = 2'($urandom);
            rb = 2'($urandom);
            if (fill_phase && $urandom_range(0, 2) != 0) re = 2'b00;
            if (!fill_phase && $urandom_range(0, 2) != 0) we = 2'b00;
            cycle(fl, we, re, rb, mk(), mk(), "rand");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
